// File: rtl/axi2per_res_channel_ctrl.sv
// Response half of the AXI-to-peripheral bridge: waits for the single peripheral response
// of the outstanding transaction and returns it as one AXI R beat or B response.
module axi2per_res_channel_ctrl #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_DATA_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [PER_DATA_WIDTH-1:0] per_master_r_rdata_i,
  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  output logic                      trans_r_valid_o,
  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,
  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i
);

  localparam int unused_widths = PER_ADDR_WIDTH + PER_ID_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_PER, RESP_R, RESP_B} state_t;

  state_t                    state_reg, state_next;
  logic [AXI_ID_WIDTH-1:0]   id_reg, id_next;
  logic                      we_reg, we_next;
  logic                      add2_reg, add2_next;
  logic                      r_valid_reg, r_valid_next;
  logic [AXI_DATA_WIDTH-1:0] r_data_reg, r_data_next;
  logic [1:0]                r_resp_reg, r_resp_next;
  logic                      r_last_reg, r_last_next;
  logic [AXI_ID_WIDTH-1:0]   r_id_reg, r_id_next;
  logic                      b_valid_reg, b_valid_next;
  logic [1:0]                b_resp_reg, b_resp_next;
  logic [AXI_ID_WIDTH-1:0]   b_id_reg, b_id_next;
  logic [AXI_DATA_WIDTH-1:0] rdata_placed;
  logic [1:0]                per_resp;
  logic                      unused_add;

  assign unused_add = ^{trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0], add2_reg};
  assign per_resp   = per_master_r_opc_i ? 2'b10 : 2'b00;

  // A 32-bit peripheral word lands in the 64-bit lane selected by address bit 2.
  generate
    if (PER_DATA_WIDTH == 32) begin : g_narrow
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign rdata_placed[gi*32 +: 32] = (add2_reg == 1'(gi)) ? per_master_r_rdata_i : 32'h0;
      end
    end else begin : g_wide
      assign rdata_placed = per_master_r_rdata_i;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    id_next         = id_reg;
    we_next         = we_reg;
    add2_next       = add2_reg;
    r_valid_next    = r_valid_reg;
    r_data_next     = r_data_reg;
    r_resp_next     = r_resp_reg;
    r_last_next     = r_last_reg;
    r_id_next       = r_id_reg;
    b_valid_next    = b_valid_reg;
    b_resp_next     = b_resp_reg;
    b_id_next       = b_id_reg;
    trans_r_valid_o = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trans_req_i) begin
          id_next    = trans_id_i;
          we_next    = trans_we_i;
          add2_next  = trans_add_i[2];
          state_next = WAIT_PER;
        end
      end
      WAIT_PER: begin
        if (per_master_r_valid_i) begin
          if (we_reg) begin
            r_valid_next = 1'b1;
            r_data_next  = rdata_placed;
            r_resp_next  = per_resp;
            r_last_next  = 1'b1;
            r_id_next    = id_reg;
            state_next   = RESP_R;
          end else begin
            b_valid_next = 1'b1;
            b_resp_next  = per_resp;
            b_id_next    = id_reg;
            state_next   = RESP_B;
          end
        end
      end
      RESP_R: begin
        if (axi_slave_r_ready_i) begin
          trans_r_valid_o = 1'b1;
          r_valid_next    = 1'b0;
          r_data_next     = '0;
          r_resp_next     = 2'b00;
          r_last_next     = 1'b0;
          r_id_next       = '0;
          state_next      = IDLE;
        end
      end
      RESP_B: begin
        if (axi_slave_b_ready_i) begin
          trans_r_valid_o = 1'b1;
          b_valid_next    = 1'b0;
          b_resp_next     = 2'b00;
          b_id_next       = '0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      id_reg      <= '0;
      we_reg      <= 1'b0;
      add2_reg    <= 1'b0;
      r_valid_reg <= 1'b0;
      r_data_reg  <= '0;
      r_resp_reg  <= 2'b00;
      r_last_reg  <= 1'b0;
      r_id_reg    <= '0;
      b_valid_reg <= 1'b0;
      b_resp_reg  <= 2'b00;
      b_id_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      id_reg      <= id_next;
      we_reg      <= we_next;
      add2_reg    <= add2_next;
      r_valid_reg <= r_valid_next;
      r_data_reg  <= r_data_next;
      r_resp_reg  <= r_resp_next;
      r_last_reg  <= r_last_next;
      r_id_reg    <= r_id_next;
      b_valid_reg <= b_valid_next;
      b_resp_reg  <= b_resp_next;
      b_id_reg    <= b_id_next;
    end
  end

  assign axi_slave_r_valid_o = r_valid_reg;
  assign axi_slave_r_data_o  = r_data_reg;
  assign axi_slave_r_resp_o  = r_resp_reg;
  assign axi_slave_r_last_o  = r_last_reg;
  assign axi_slave_r_id_o    = r_id_reg;
  assign axi_slave_r_user_o  = '0;
  assign axi_slave_b_valid_o = b_valid_reg;
  assign axi_slave_b_resp_o  = b_resp_reg;
  assign axi_slave_b_id_o    = b_id_reg;
  assign axi_slave_b_user_o  = '0;

`ifndef SYNTHESIS
  // Spurious events are dropped by the FSM; flag them so integration bugs are visible.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(per_master_r_valid_i && state_reg != WAIT_PER))
        else $warning("per_master_r_valid_i outside WAIT_PER dropped");
      assert (!(trans_req_i && state_reg != IDLE))
        else $warning("trans_req_i outside IDLE ignored");
      assert (!(r_valid_reg && b_valid_reg))
        else $error("R and B valid in the same cycle");
    end
  end
`endif

endmodule

// File: tb/tb_axi2per_res_channel_ctrl.sv
// Scoreboard bench for axi2per_res_channel_ctrl: expected beats are queued when the
// peripheral response is driven and compared when the AXI handshake happens.
module tb_axi2per_res_channel_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        per_valid = 1'b0;
  logic        per_opc = 1'b0;
  logic [31:0] per_rdata = '0;
  logic        trans_req = 1'b0;
  logic        trans_we = 1'b0;
  logic [2:0]  trans_id = '0;
  logic [31:0] trans_add = '0;
  logic        trans_r_valid;
  logic        r_valid, r_last, r_ready = 1'b1;
  logic [63:0] r_data;
  logic [1:0]  r_resp, b_resp;
  logic [2:0]  r_id, b_id;
  logic [5:0]  r_user, b_user;
  logic        b_valid, b_ready = 1'b1;

  axi2per_res_channel_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .per_master_r_valid_i(per_valid), .per_master_r_opc_i(per_opc),
    .per_master_r_rdata_i(per_rdata),
    .trans_req_i(trans_req), .trans_we_i(trans_we), .trans_id_i(trans_id),
    .trans_add_i(trans_add), .trans_r_valid_o(trans_r_valid),
    .axi_slave_r_valid_o(r_valid), .axi_slave_r_data_o(r_data),
    .axi_slave_r_resp_o(r_resp), .axi_slave_r_last_o(r_last),
    .axi_slave_r_id_o(r_id), .axi_slave_r_user_o(r_user),
    .axi_slave_r_ready_i(r_ready),
    .axi_slave_b_valid_o(b_valid), .axi_slave_b_resp_o(b_resp),
    .axi_slave_b_id_o(b_id), .axi_slave_b_user_o(b_user),
    .axi_slave_b_ready_i(b_ready)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic [2:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   r_beats = 0, b_beats = 0, trans_pulses = 0;
  int   r_cyc = 0, b_cyc = 0, last_r_cyc = 0, last_b_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lane placement of a 32-bit peripheral word into the 64-bit R data bus.
  function automatic logic [63:0] place(input logic [31:0] addr, input logic [31:0] d);
    return addr[2] ? {d, 32'h0} : {32'h0, d};
  endfunction

  // Monitor: sample away from the active edge.
  logic        prev_r_pend = 1'b0, prev_b_pend = 1'b0;
  logic [63:0] prev_r_data;
  logic [2:0]  prev_r_id, prev_b_id;
  logic [1:0]  prev_r_resp, prev_b_resp;

  always @(negedge clk_i) begin
    logic hs_r, hs_b;
    exp_t e;
    if (!rst_ni) begin
      prev_r_pend = 1'b0; prev_b_pend = 1'b0; r_cyc = 0; b_cyc = 0;
    end else begin
      hs_r = r_valid & r_ready;
      hs_b = b_valid & b_ready;
      check("rb_exclusive", {63'b0, r_valid & b_valid}, 64'd0);
      check("trans_r_valid", {63'b0, trans_r_valid}, {63'b0, hs_r | hs_b});
      check("user_zero", {52'b0, r_user, b_user}, 64'd0);
      if (trans_r_valid) trans_pulses++;
      if (!r_valid) begin
        check("r_idle_data", r_data, 64'd0);
        check("r_idle_ctrl", {58'b0, r_resp, r_id, r_last}, 64'd0);
      end
      if (!b_valid) check("b_idle_ctrl", {59'b0, b_resp, b_id}, 64'd0);
      if (r_valid && prev_r_pend) begin
        check("r_stable_data", r_data, prev_r_data);
        check("r_stable_ctrl", {59'b0, r_resp, r_id}, {59'b0, prev_r_resp, prev_r_id});
      end
      if (b_valid && prev_b_pend)
        check("b_stable_ctrl", {59'b0, b_resp, b_id}, {59'b0, prev_b_resp, prev_b_id});
      if (r_valid) r_cyc++;
      if (b_valid) b_cyc++;
      if (hs_r || hs_b) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("beat_kind", {63'b0, hs_r}, {63'b0, e.rd});
          if (hs_r) begin
            check("r_data", r_data, e.data);
            check("r_resp", {62'b0, r_resp}, {62'b0, e.resp});
            check("r_last", {63'b0, r_last}, 64'd1);
            check("r_id", {61'b0, r_id}, {61'b0, e.id});
          end else begin
            check("b_resp", {62'b0, b_resp}, {62'b0, e.resp});
            check("b_id", {61'b0, b_id}, {61'b0, e.id});
          end
        end
      end
      if (hs_r) begin r_beats++; last_r_cyc = r_cyc; r_cyc = 0; end
      if (hs_b) begin b_beats++; last_b_cyc = b_cyc; b_cyc = 0; end
      prev_r_pend = r_valid & ~r_ready;
      prev_b_pend = b_valid & ~b_ready;
      prev_r_data = r_data; prev_r_id = r_id; prev_r_resp = r_resp;
      prev_b_id = b_id; prev_b_resp = b_resp;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("beat_timeout", 64'd1, 64'd0);
      sb.delete();
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns after the response has been consumed.
  task automatic do_trans(input logic rd, input logic [2:0] id, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic opc, input int gap,
                          input int stall);
    exp_t e;
    trans_req = 1'b1; trans_we = rd; trans_id = id; trans_add = addr;
    @(posedge clk_i); #1;
    trans_req = 1'b0; trans_we = 1'b0; trans_id = '0; trans_add = '0;
    repeat (gap - 1) begin @(posedge clk_i); #1; end
    per_valid = 1'b1; per_rdata = rdata; per_opc = opc;
    if (stall > 0) begin r_ready = 1'b0; b_ready = 1'b0; end
    e.rd = rd; e.id = id; e.data = rd ? place(addr, rdata) : 64'd0; e.resp = opc ? 2'b10 : 2'b00;
    sb.push_back(e);
    @(posedge clk_i); #1;
    per_valid = 1'b0; per_rdata = '0; per_opc = 1'b0;
    check("valid_latency", {63'b0, rd ? r_valid : b_valid}, 64'd1);
    repeat (stall) begin @(posedge clk_i); #1; end
    r_ready = 1'b1; b_ready = 1'b1;
    wait_done();
  endtask

  initial begin
    int tp0, rb0, bb0;
    #1;
    check("rst_valids", {61'b0, trans_r_valid, r_valid, b_valid}, 64'd0);
    check("rst_r_data", r_data, 64'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    tp0 = trans_pulses; rb0 = r_beats;
    do_trans(1'b1, 3'd3, 32'h1000, 32'hDEADBEEF, 1'b0, 2, 0);
    check("t1_pulses", 64'(trans_pulses - tp0), 64'd1);
    check("t1_r_beats", 64'(r_beats - rb0), 64'd1);

    do_trans(1'b1, 3'd5, 32'h1004, 32'hCAFEF00D, 1'b0, 1, 0);

    tp0 = trans_pulses;
    do_trans(1'b0, 3'd2, 32'h2000, 32'h0, 1'b0, 1, 3);
    check("t3_b_valid_cycles", 64'(last_b_cyc), 64'd4);
    check("t3_pulses", 64'(trans_pulses - tp0), 64'd1);

    do_trans(1'b1, 3'd1, 32'h3008, 32'h12345678, 1'b1, 1, 0);
    do_trans(1'b0, 3'd7, 32'h300C, 32'h0, 1'b1, 2, 0);

    rb0 = r_beats; bb0 = b_beats;
    do_trans(1'b1, 3'd4, 32'h4000, 32'hA5A5A5A5, 1'b0, 1, 0);
    do_trans(1'b0, 3'd6, 32'h4004, 32'h0, 1'b0, 1, 0);
    check("t5_r_beats", 64'(r_beats - rb0), 64'd1);
    check("t5_b_beats", 64'(b_beats - bb0), 64'd1);
    check("t5_r_valid_cycles", 64'(last_r_cyc), 64'd1);

    for (int i = 0; i < 8; i++) begin
      do_trans(1'($urandom_range(0, 1)), 3'($urandom), $urandom & 32'hFFFF_FFFC,
               $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
               int'($urandom_range(0, 2)));
    end

    // Reset while the R beat is stalled, then a stray peripheral pulse in IDLE.
    rb0 = r_beats;
    trans_req = 1'b1; trans_we = 1'b1; trans_id = 3'd3; trans_add = 32'h5000;
    @(posedge clk_i); #1;
    trans_req = 1'b0;
    per_valid = 1'b1; per_rdata = 32'h55AA55AA; r_ready = 1'b0;
    @(posedge clk_i); #1;
    per_valid = 1'b0;
    check("t6_in_resp_r", {63'b0, r_valid}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valids", {61'b0, trans_r_valid, r_valid, b_valid}, 64'd0);
    check("t6_rst_r_data", r_data, 64'd0);
    check("t6_rst_ctrl", {56'b0, r_resp, r_id, b_resp, r_last}, 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; r_ready = 1'b1;
    per_valid = 1'b1; per_rdata = 32'hFFFFFFFF;
    @(posedge clk_i); #1;
    per_valid = 1'b0; per_rdata = '0;
    repeat (3) begin
      check("t6_no_beat", {62'b0, r_valid, b_valid}, 64'd0);
      @(posedge clk_i); #1;
    end
    check("t6_r_beats", 64'(r_beats - rb0), 64'd0);
    do_trans(1'b1, 3'd6, 32'h6004, 32'h0BADC0DE, 1'b0, 1, 0);
    check("t6_recovered", 64'(r_beats - rb0), 64'd1);

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
